// File: rtl/vp_pkg.sv
// ---------------------------------------------------------------------------
// vp_pkg
// Shared definitions for the last-value prediction table.
//   VP_ADDR_WIDTH / VP_DATA_WIDTH : load PC and load data widths
//   VP_CONF_WIDTH / VP_CONF_THRESHOLD : default confidence configuration
//   vp_entry_t : one table entry. The tag and conf fields are sized for the
//                widest legal configuration; narrower configurations keep
//                the upper bits at zero.
//   vp_tag_width() : tag width for a given index width
// ---------------------------------------------------------------------------
package vp_pkg;

    localparam int VP_ADDR_WIDTH     = 32;
    localparam int VP_DATA_WIDTH     = 32;
    localparam int VP_CONF_WIDTH     = 2;
    localparam int VP_CONF_THRESHOLD = 2;

    // Largest tag (index width 0) and largest supported confidence counter.
    localparam int VP_TAG_MAX_W  = VP_ADDR_WIDTH - 2;
    localparam int VP_CONF_MAX_W = 8;

    typedef struct packed {
        logic                     valid;
        logic [VP_TAG_MAX_W-1:0]  tag;
        logic [VP_DATA_WIDTH-1:0] value;
        logic [VP_CONF_MAX_W-1:0] conf;
    } vp_entry_t;

    // PC[1:0] is the word offset and PC[index_width+1:2] the index; the
    // rest of the PC is the tag.
    function automatic int vp_tag_width(input int index_width);
        return VP_ADDR_WIDTH - index_width - 2;
    endfunction

endpackage

// File: rtl/vp_value_table_if.sv
// ---------------------------------------------------------------------------
// vp_value_table_if
// Front-end <-> prediction-table bus.
//   lookup_en/lookup_pc          : lookup request (front end -> table)
//   pred_valid/pc/data/hit/confident : registered lookup result (table -> front end)
//   train_en/train_pc/train_data : resolved load value (d-cache -> table)
//   flush_en                     : invalidate the whole table
// master = requester side, slave = table side.
// ---------------------------------------------------------------------------
interface vp_value_table_if;
    import vp_pkg::*;

    logic                     lookup_en;
    logic [VP_ADDR_WIDTH-1:0] lookup_pc;

    logic                     pred_valid;
    logic [VP_ADDR_WIDTH-1:0] pred_pc;
    logic [VP_DATA_WIDTH-1:0] pred_data;
    logic                     pred_hit;
    logic                     pred_confident;

    logic                     train_en;
    logic [VP_ADDR_WIDTH-1:0] train_pc;
    logic [VP_DATA_WIDTH-1:0] train_data;

    logic                     flush_en;

    modport master (
        output lookup_en, lookup_pc, train_en, train_pc, train_data, flush_en,
        input  pred_valid, pred_pc, pred_data, pred_hit, pred_confident
    );

    modport slave (
        input  lookup_en, lookup_pc, train_en, train_pc, train_data, flush_en,
        output pred_valid, pred_pc, pred_data, pred_hit, pred_confident
    );

endinterface

// File: rtl/vp_sat_counter.sv
// ---------------------------------------------------------------------------
// vp_sat_counter
// Up-counter that sticks at all ones instead of wrapping.
//   clk, rst_n : clock, asynchronous active-low reset (count -> 0)
//   i_inc      : add one this cycle (ignored once saturated)
//   i_clear    : synchronous clear, wins over i_inc
//   o_count    : current count
// ---------------------------------------------------------------------------
module vp_sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_inc,
    input  logic             i_clear,
    output logic [WIDTH-1:0] o_count
);

    logic [WIDTH-1:0] r_count;

    function automatic logic [WIDTH-1:0] sat_inc(input logic [WIDTH-1:0] v);
        return (v == '1) ? v : v + WIDTH'(1);
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_inc) begin
            r_count <= sat_inc(r_count);
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/vp_value_table.sv
// ---------------------------------------------------------------------------
// vp_value_table
// PC-indexed last-value prediction table with saturating confidence.
//   clk, rst_n    : clock, asynchronous active-low reset
//   bus (slave)   : lookup request, registered prediction result, training
//                   input and flush (see vp_value_table_if)
//   stat_correct  : confident predictions that matched the trained value
//   stat_wrong    : confident predictions that did not match
// Lookup result appears one cycle after lookup_en. Training updates the entry
// at the following edge; a same-cycle lookup sees the pre-train entry.
// Storage is flops so that flush can clear every entry in one cycle.
// ---------------------------------------------------------------------------
module vp_value_table
    import vp_pkg::*;
#(
    parameter int INDEX_WIDTH    = 6,
    parameter int CONF_WIDTH     = VP_CONF_WIDTH,
    parameter int CONF_THRESHOLD = VP_CONF_THRESHOLD,
    parameter int STAT_WIDTH     = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    vp_value_table_if.slave       bus,
    output logic [STAT_WIDTH-1:0] stat_correct,
    output logic [STAT_WIDTH-1:0] stat_wrong
);

    localparam int ENTRIES = 1 << INDEX_WIDTH;
    localparam int TAG_W   = vp_tag_width(INDEX_WIDTH);

    localparam logic [CONF_WIDTH-1:0]    CONF_MAX = '1;
    localparam logic [VP_CONF_MAX_W-1:0] CONF_TH  = VP_CONF_MAX_W'(CONF_THRESHOLD);

    function automatic logic [CONF_WIDTH-1:0] conf_sat_inc(input logic [CONF_WIDTH-1:0] c);
        return (c == CONF_MAX) ? c : c + CONF_WIDTH'(1);
    endfunction

    vp_entry_t r_table [ENTRIES];

    logic                     r_pred_valid;
    logic [VP_ADDR_WIDTH-1:0] r_pred_pc;
    logic [VP_DATA_WIDTH-1:0] r_pred_data;
    logic                     r_pred_hit;
    logic                     r_pred_confident;

    // ---- index / tag extraction ----
    logic [INDEX_WIDTH-1:0]  w_lk_idx;
    logic [INDEX_WIDTH-1:0]  w_tr_idx;
    logic [VP_TAG_MAX_W-1:0] w_lk_tag;
    logic [VP_TAG_MAX_W-1:0] w_tr_tag;
    logic [1:0]              w_unused_train_lo;

    assign w_lk_idx = bus.lookup_pc[INDEX_WIDTH+1:2];
    assign w_tr_idx = bus.train_pc[INDEX_WIDTH+1:2];
    assign w_lk_tag = VP_TAG_MAX_W'(bus.lookup_pc[VP_ADDR_WIDTH-1:VP_ADDR_WIDTH-TAG_W]);
    assign w_tr_tag = VP_TAG_MAX_W'(bus.train_pc[VP_ADDR_WIDTH-1:VP_ADDR_WIDTH-TAG_W]);
    // Word offset of the training PC carries no information for the table.
    assign w_unused_train_lo = bus.train_pc[1:0];

    // ---- lookup side ----
    vp_entry_t w_lk_ent;
    logic      w_lk_hit;
    logic      w_lk_conf_ok;

    assign w_lk_ent     = r_table[w_lk_idx];
    // A lookup coinciding with flush reports a miss.
    assign w_lk_hit     = w_lk_ent.valid && (w_lk_ent.tag == w_lk_tag) && !bus.flush_en;
    assign w_lk_conf_ok = (w_lk_ent.conf >= CONF_TH);

    // ---- train side (pre-update entry state) ----
    vp_entry_t w_tr_ent;
    logic      w_tr_do;
    logic      w_tr_hit;
    logic      w_tr_eq;
    logic      w_tr_conf_ok;
    logic      w_inc_correct;
    logic      w_inc_wrong;

    assign w_tr_ent      = r_table[w_tr_idx];
    // Flush drops a coincident train entirely, including its statistics.
    assign w_tr_do       = bus.train_en && !bus.flush_en;
    assign w_tr_hit      = w_tr_ent.valid && (w_tr_ent.tag == w_tr_tag);
    assign w_tr_eq       = (w_tr_ent.value == bus.train_data);
    assign w_tr_conf_ok  = (w_tr_ent.conf >= CONF_TH);
    assign w_inc_correct = w_tr_do && w_tr_hit && w_tr_conf_ok && w_tr_eq;
    assign w_inc_wrong   = w_tr_do && w_tr_hit && w_tr_conf_ok && !w_tr_eq;

    // ---- table update ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_table[i] <= '0;
            end
        end else if (bus.flush_en) begin
            // Values and tags are left in place; only valid/conf are cleared.
            for (int i = 0; i < ENTRIES; i++) begin
                r_table[i].valid <= 1'b0;
                r_table[i].conf  <= '0;
            end
        end else if (bus.train_en) begin
            if (w_tr_hit) begin
                if (w_tr_eq) begin
                    r_table[w_tr_idx].conf <=
                        VP_CONF_MAX_W'(conf_sat_inc(w_tr_ent.conf[CONF_WIDTH-1:0]));
                end else begin
                    r_table[w_tr_idx].value <= bus.train_data;
                    r_table[w_tr_idx].conf  <= '0;
                end
            end else begin
                r_table[w_tr_idx] <= '{valid: 1'b1,
                                       tag:   w_tr_tag,
                                       value: bus.train_data,
                                       conf:  '0};
            end
        end
    end

    // ---- registered lookup result ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pred_valid     <= 1'b0;
            r_pred_pc        <= '0;
            r_pred_data      <= '0;
            r_pred_hit       <= 1'b0;
            r_pred_confident <= 1'b0;
        end else begin
            r_pred_valid <= bus.lookup_en;
            // Result fields hold between lookups; consumers qualify with pred_valid.
            if (bus.lookup_en) begin
                r_pred_pc        <= bus.lookup_pc;
                r_pred_hit       <= w_lk_hit;
                r_pred_data      <= w_lk_hit ? w_lk_ent.value : '0;
                r_pred_confident <= w_lk_hit && w_lk_conf_ok;
            end
        end
    end

    assign bus.pred_valid     = r_pred_valid;
    assign bus.pred_pc        = r_pred_pc;
    assign bus.pred_data      = r_pred_data;
    assign bus.pred_hit       = r_pred_hit;
    assign bus.pred_confident = r_pred_confident;

    // ---- accuracy statistics ----
    vp_sat_counter #(.WIDTH(STAT_WIDTH)) u_stat_correct (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_inc   (w_inc_correct),
        .i_clear (1'b0),
        .o_count (stat_correct)
    );

    vp_sat_counter #(.WIDTH(STAT_WIDTH)) u_stat_wrong (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_inc   (w_inc_wrong),
        .i_clear (1'b0),
        .o_count (stat_wrong)
    );

endmodule

// File: doc/vp_value_table.md
# vp_value_table

Last-value prediction table that supplies predicted load data and a confidence flag to the value-prediction front end, and trains itself from resolved d-cache load responses. It sits beside the MEM stage. The front end issues a PC lookup when a load misses in the d-cache; the d-cache response path writes back the real value. The block replaces the fixed all-zero prediction with PC-indexed last values gated by saturating confidence counters.

## Interface
Parameters:
- INDEX_WIDTH, 6, table index bits (2^INDEX_WIDTH entries), taken from PC[INDEX_WIDTH+1:2].
- CONF_WIDTH, 2, confidence counter bits.
- CONF_THRESHOLD, 2, minimum confidence for pred_confident.
- STAT_WIDTH, 16, width of accuracy counters.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- lookup_en  in  1  lookup request, one cycle.
- lookup_pc  in  `ADDR_WIDTH  load PC to predict.
- pred_valid  out  1  prediction result valid, one-cycle pulse.
- pred_pc  out  `ADDR_WIDTH  PC the result belongs to.
- pred_data  out  `DATA_WIDTH  predicted value.
- pred_hit  out  1  entry valid and tag matched.
- pred_confident  out  1  pred_hit and conf >= CONF_THRESHOLD.
- train_en  in  1  resolved load value available, one cycle.
- train_pc  in  `ADDR_WIDTH  PC of resolved load.
- train_data  in  `DATA_WIDTH  actual loaded value.
- flush_en  in  1  invalidate entire table.
- stat_correct  out  STAT_WIDTH  confident-and-correct count.
- stat_wrong  out  STAT_WIDTH  confident-and-wrong count.

## Operation
- Entry fields: valid, tag = PC[`ADDR_WIDTH-1:INDEX_WIDTH+2], value, conf.
- Lookup:
  - Reads the entry at index(lookup_pc).
  - The result is registered and appears on the next cycle.
  - On a miss: pred_data = 0, pred_hit = 0, pred_confident = 0.
- Train at index(train_pc):
  - Hit, value equal: conf saturating +1, capped at 2^CONF_WIDTH-1.
  - Hit, value differs: value <= train_data, conf <= 0.
  - Miss (invalid entry or tag mismatch): allocate the entry. valid <= 1, tag, value <= train_data, conf <= 0.
- Statistics, evaluated on train_en only, using pre-update entry state:
  - Hit with conf >= CONF_THRESHOLD and equal value: stat_correct +1.
  - Hit with conf >= CONF_THRESHOLD and differing value: stat_wrong +1.
  - Both counters saturate at all ones and never wrap.
- Flush: all valid <= 0 and all conf <= 0 at the next edge. Values and statistics are kept.
- Priority and simultaneous events:
  - flush_en overrides train_en in the same cycle; the train is dropped and no statistic is counted.
  - A lookup in the same cycle as flush_en returns a miss.
  - A lookup and a train to the same index in the same cycle: the lookup sees pre-train contents.
  - A lookup and a train to different indices proceed independently.
- Reset, asynchronous:
  - All entries: valid = 0, conf = 0, value = 0, tag = 0.
  - pred_valid, pred_hit, pred_confident = 0; pred_pc, pred_data = 0.
  - stat_correct, stat_wrong = 0.
  - Reset mid-operation drops any registered result; no pred_valid pulse follows the reset.

## Timing
- Lookup latency is 1 cycle: lookup_en at edge N gives pred_valid high for exactly cycle N+1. Back-to-back lookups give back-to-back pulses.
- Train takes effect at the edge after train_en. A lookup issued in that following cycle sees the updated entry.
- No stalls and no backpressure: one lookup and one train are accepted every cycle.
- pred_* outputs hold their last values while pred_valid = 0. Consumers must qualify them with pred_valid.
- Statistic counters update at the same edge as the corresponding train.

## Structure
- Shared package vp_pkg:
  - vp_entry_t struct (valid, tag, value, conf).
  - Tag width function of `ADDR_WIDTH and INDEX_WIDTH.
  - Default CONF_WIDTH and CONF_THRESHOLD constants.
- Sub-module vp_sat_counter: parameterized width, inc and clear inputs, saturates at all ones. Instanced for both statistic counters; the same increment logic is used for the per-entry conf update.
- Table storage is flops (no SRAM macro), because flush must clear every entry in a single cycle.

## Test plan
- Cold lookup: reset, then lookup 0x0040_0010 -> next cycle pred_valid = 1, pred_hit = 0, pred_data = 0, pred_confident = 0.
- Confidence ramp: train 0x0040_0010 with 0xDEAD_BEEF three times, lookup after each.
  - Expect conf 0, 1, 2; pred_confident goes high only after the third train.
  - A fourth and fifth equal train keep conf saturated at 3.
- Mispredict: at conf 3, train 0x0040_0010 with 0x1234_5678 -> stat_wrong = 1, conf = 0, next lookup returns pred_data = 0x1234_5678 with pred_confident = 0.
- Aliasing: train 0x0040_0010 then 0x0040_0110 (same index 4, different tag) -> second replaces first; lookup 0x0040_0010 misses.
- Simultaneous events:
  - Lookup and train to the same index in one cycle -> lookup returns the old value.
  - flush_en together with train_en -> entry stays invalid, stat counters unchanged.
- Saturation and reset: force stat_correct to 0xFFFF, then one more confident correct train -> stat_correct stays 0xFFFF. Assert rst_n low mid-lookup -> pred_valid = 0 immediately, no pulse after release.
